// File: rtl/enc_pkg.sv
// Shared definitions for the streaming polar encoder.
//   state_t   : encoder FSM states.
//   logn()    : log2 of the codeword length (number of butterfly stages).
//   beats()   : number of output beats per codeword.
//   popcount(): number of set bits in a mask of up to MAX_N bits.
package enc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUILD,
      XFORM,
      SHIFT
   } state_t;

   localparam int MAX_N = 1024;

   function automatic int logn(input int n);
      return $clog2(n);
   endfunction

   function automatic int beats(input int n, input int w);
      return n / w;
   endfunction

   function automatic int popcount(input logic [MAX_N-1:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < MAX_N; i++) begin
         cnt += int'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/polar_butterfly_stage.sv
// One combinational stage of the polar transform F (x) n.
//   x_in  : current N-bit vector.
//   s     : stage index 0..log2(N)-1.
//   x_out : x_out[i] = x_in[i] ^ x_in[i + 2^s] when bit s of i is 0,
//           otherwise x_out[i] = x_in[i].
module polar_butterfly_stage
   import enc_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]         x_in,
   input  logic [$clog2(N)-1:0] s,
   output logic [N-1:0]         x_out
);

   localparam int LOGN = logn(N);

   always_comb begin
      x_out = x_in;
      for (int k = 0; k < LOGN; k++) begin
         if (int'(s) == k) begin
            for (int i = 0; i < N; i++) begin
               // With bit k of i clear, i | 2^k equals i + 2^k and is always in range.
               if (((i >> k) & 1) == 0) begin
                  x_out[i] = x_in[i] ^ x_in[i | (1 << k)];
               end
            end
         end
      end
   end

endmodule

// File: rtl/polar_enc_stream.sv
// Streaming polar encoder.
//   clk, rst            : rising-edge clock, synchronous active-low reset.
//   msg_valid/msg_ready : message + frozen mask handshake (accepted in IDLE only).
//   msg_in [K]          : message; bit 0 fills the lowest non-frozen index.
//   f_mask [N]          : frozen mask, 1 = frozen (u forced to 0).
//   out_valid/out_ready : codeword beat handshake.
//   out_data [W]        : codeword bits, LSB = lowest codeword index of the beat.
//   out_last            : final beat of the codeword.
//   cfg_err             : one-cycle pulse when the mask does not have exactly K zeros.
module polar_enc_stream
   import enc_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         msg_valid,
   output logic         msg_ready,
   input  logic [K-1:0] msg_in,
   input  logic [N-1:0] f_mask,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         cfg_err
);

   localparam int LOGN  = logn(N);
   localparam int BEATS = beats(N, W);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_t         state;
   logic [K-1:0]   msg_q;
   logic [N-1:0]   mask_q;
   logic [N-1:0]   x_q;
   logic [LOGN-1:0] stage_q;
   logic [BW-1:0]  beat_q;
   logic [BW-1:0]  beat_nxt;
   logic [N-1:0]   u;
   logic [N-1:0]   x_stage;

   assign msg_ready = rst && (state == IDLE);
   assign beat_nxt  = beat_q + 1'b1;

   // Scatter the message into the non-frozen positions in ascending index order.
   always_comb begin : scatter
      int q;
      // NOTE: every combinationally assigned variable gets a default first so no latch is inferred.
      u = '0;
      q = 0;
      for (int i = 0; i < N; i++) begin
         if (!mask_q[i]) begin
            if (q < K) begin
               u[i] = msg_q[q];
            end
            q++;
         end
      end
   end

   polar_butterfly_stage #(.N(N)) u_stage (
      .x_in  (x_q),
      .s     (stage_q),
      .x_out (x_stage)
   );

   // NOTE: state is updated with non-blocking assignments only, so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: data registers are cleared along with control so out_data reads 0 straight out of reset.
         state     <= IDLE;
         msg_q     <= '0;
         mask_q    <= '0;
         x_q       <= '0;
         stage_q   <= '0;
         beat_q    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (msg_valid) begin
                  msg_q  <= msg_in;
                  mask_q <= f_mask;
                  // Checked at acceptance so the registered pulse lands in the BUILD cycle.
                  cfg_err <= ((N - popcount(MAX_N'(f_mask))) != K);
                  state  <= BUILD;
               end
            end
            BUILD: begin
               if (cfg_err) begin
                  state <= IDLE;
               end else begin
                  x_q     <= u;
                  stage_q <= '0;
                  state   <= XFORM;
               end
            end
            XFORM: begin
               x_q <= x_stage;
               if (stage_q == LOGN'(LOGN - 1)) begin
                  // Present beat 0 directly from the final stage output.
                  state     <= SHIFT;
                  beat_q    <= '0;
                  out_valid <= 1'b1;
                  out_data  <= x_stage[W-1:0];
                  out_last  <= (BEATS == 1);
               end else begin
                  stage_q <= stage_q + 1'b1;
               end
            end
            SHIFT: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_data  <= '0;
                  end else begin
                     beat_q   <= beat_nxt;
                     out_data <= x_q[beat_nxt*W +: W];
                     out_last <= (beat_nxt == BW'(BEATS - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_polar_enc_stream.sv
// Self-checking bench for polar_enc_stream (N=8, K=4, W=2).
module tb_polar_enc_stream;

   localparam int N     = 8;
   localparam int K     = 4;
   localparam int W     = 2;
   localparam int BEATS = N / W;
   localparam int LOGN  = 3;
   localparam logic [N-1:0] STD_MASK = 8'b0001_0111;

   logic         clk = 1'b0;
   logic         rst;
   logic         msg_valid;
   logic         msg_ready;
   logic [K-1:0] msg_in;
   logic [N-1:0] f_mask;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         cfg_err;

   int checks   = 0;
   int failures = 0;

   polar_enc_stream #(.N(N), .K(K), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .msg_valid (msg_valid),
      .msg_ready (msg_ready),
      .msg_in    (msg_in),
      .f_mask    (f_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: scatter by the mask, then x[i] = XOR of u[j] over all j that contain i.
   function automatic logic [N-1:0] model_x(input logic [K-1:0] m, input logic [N-1:0] f);
      logic [N-1:0] u;
      logic [N-1:0] x;
      int q;
      u = '0;
      q = 0;
      for (int i = 0; i < N; i++) begin
         if (!f[i]) begin
            if (q < K) u[i] = m[q];
            q++;
         end
      end
      x = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if ((j & i) == i) x[i] = x[i] ^ u[j];
      return x;
   endfunction

   typedef struct {
      logic [N-1:0] x;
      int nbeats;
      int first_valid;
      int err_cycles;
      int err_first;
      int ready_cycle;
      int valid_cycles;
      int bad_last;
      int unstable;
      int extra_accept;
      int timeout;
   } res_t;

   // Offers one message, then collects beats until out_last is handshaken,
   // the post-error msg_ready is seen, or the abort beat is reached.
   task automatic run_frame(input logic [K-1:0] m, input logic [N-1:0] f,
                            input int bp_beat, input int bp_len, input bit rand_ready,
                            input bit hold_valid, input int abort_at, output res_t r);
      int stall;
      int guard;
      bit prev_stall;
      bit done;
      logic [W-1:0] pd;
      logic pl;
      r = '{default: 0};
      r.first_valid = -1;
      r.err_first   = -1;
      r.ready_cycle = -1;
      stall = 0;
      prev_stall = 1'b0;
      done = 1'b0;
      pd = '0;
      pl = 1'b0;
      guard = 0;
      while (!msg_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!msg_ready) begin
         r.timeout = 1;
         return;
      end
      msg_in    = m;
      f_mask    = f;
      msg_valid = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(negedge clk);
         if (!hold_valid) msg_valid = 1'b0;
         if (msg_valid && msg_ready) r.extra_accept++;
         if (cfg_err) begin
            r.err_cycles++;
            if (r.err_first < 0) r.err_first = cyc;
         end
         if (r.err_cycles > 0 && msg_ready) begin
            r.ready_cycle = cyc;
            done = 1'b1;
         end
         if (out_valid) begin
            r.valid_cycles++;
            if (r.first_valid < 0) r.first_valid = cyc;
            if (prev_stall && (out_data !== pd || out_last !== pl)) r.unstable++;
         end else if (prev_stall) begin
            r.unstable++;
         end
         if (abort_at >= 0 && out_valid && r.nbeats == abort_at) begin
            out_ready = 1'b0;
            done = 1'b1;
         end else if (!done) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            else if (r.nbeats == bp_beat && stall < bp_len) begin
               out_ready = 1'b0;
               stall++;
            end else out_ready = 1'b1;
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (out_valid && out_ready) begin
               if (r.nbeats < BEATS) r.x[r.nbeats*W +: W] = out_data;
               if (out_last !== (r.nbeats == BEATS - 1)) r.bad_last++;
               r.nbeats++;
               if (out_last) begin
                  done = 1'b1;
                  msg_valid = 1'b0;
               end
            end
         end
      end
      if (!done) r.timeout = 1;
      msg_valid = 1'b0;
   endtask

   typedef struct {
      string        name;
      logic [K-1:0] msg;
      logic [N-1:0] mask;
      logic [N-1:0] exp_x;
      bit           exp_err;
   } vec_t;

   vec_t vecs[6];
   res_t r;

   initial begin
      rst       = 1'b0;
      msg_valid = 1'b0;
      msg_in    = '0;
      f_mask    = '0;
      out_ready = 1'b0;

      // x is the set of indices contained in the single set u index, as a bitmap.
      vecs[0] = '{"u7",      4'b1000, STD_MASK,     8'hFF, 1'b0};
      vecs[1] = '{"u3",      4'b0001, STD_MASK,     8'h0F, 1'b0};
      vecs[2] = '{"u5",      4'b0010, STD_MASK,     8'h33, 1'b0};
      vecs[3] = '{"u6",      4'b0100, STD_MASK,     8'h55, 1'b0};
      vecs[4] = '{"zeros5",  4'b1111, 8'b0000_0111, 8'h00, 1'b1};
      vecs[5] = '{"zeros0",  4'b1010, 8'b1111_1111, 8'h00, 1'b1};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last",  out_last,  0);
      check("rst_out_data",  out_data,  0);
      check("rst_cfg_err",   cfg_err,   0);
      check("rst_msg_ready", msg_ready, 0);
      rst = 1'b1;
      #1;
      check("first_ready_after_rst", msg_ready, 1);
      @(negedge clk);

      // Directed vectors.
      foreach (vecs[v]) begin
         run_frame(vecs[v].msg, vecs[v].mask, -1, 0, 1'b0, 1'b0, -1, r);
         check({vecs[v].name, "_timeout"}, r.timeout, 0);
         if (vecs[v].exp_err) begin
            check({vecs[v].name, "_err_cycles"}, r.err_cycles, 1);
            check({vecs[v].name, "_err_first"},  r.err_first, 1);
            check({vecs[v].name, "_ready_cyc"},  r.ready_cycle, 2);
            check({vecs[v].name, "_no_valid"},   r.valid_cycles, 0);
         end else begin
            check({vecs[v].name, "_x"},          r.x, vecs[v].exp_x);
            check({vecs[v].name, "_beats"},      r.nbeats, BEATS);
            check({vecs[v].name, "_first_vld"},  r.first_valid, LOGN + 2);
            check({vecs[v].name, "_last"},       r.bad_last, 0);
            check({vecs[v].name, "_no_err"},     r.err_cycles, 0);
         end
      end

      // Backpressure: three stall cycles on beat 1.
      run_frame(4'b0010, STD_MASK, 1, 3, 1'b0, 1'b0, -1, r);
      check("bp_timeout",  r.timeout, 0);
      check("bp_x",        r.x, 8'h33);
      check("bp_beats",    r.nbeats, BEATS);
      check("bp_stable",   r.unstable, 0);
      check("bp_valid_cy", r.valid_cycles, BEATS + 3);
      check("bp_last",     r.bad_last, 0);

      // Reset during beat 2, then a fresh message with msg_valid held throughout.
      run_frame(4'b0001, STD_MASK, -1, 0, 1'b0, 1'b0, 2, r);
      check("abort_timeout", r.timeout, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data",  out_data, 0);
      check("midrst_out_last",  out_last, 0);
      check("midrst_msg_ready", msg_ready, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ready_back", msg_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_no_stale", out_valid, 0);
      end
      run_frame(4'b1000, STD_MASK, -1, 0, 1'b0, 1'b1, -1, r);
      check("hold_timeout",   r.timeout, 0);
      check("hold_x",         r.x, 8'hFF);
      check("hold_beats",     r.nbeats, BEATS);
      check("hold_no_accept", r.extra_accept, 0);
      check("hold_first_vld", r.first_valid, LOGN + 2);

      // Randomised frames against the reference model with random out_ready.
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] f;
         logic [K-1:0] m;
         bit exp_err;
         m = K'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            f = N'($urandom);
         end else begin
            f = '1;
            for (int z = 0; z < K; z++) begin
               int p;
               p = $urandom_range(0, N - 1);
               while (!f[p]) p = (p + 1) % N;
               f[p] = 1'b0;
            end
         end
         exp_err = ($countones(~f) != K);
         run_frame(m, f, -1, 0, 1'b1, 1'b0, -1, r);
         check("rnd_timeout", r.timeout, 0);
         check("rnd_err", (r.err_cycles > 0), exp_err);
         if (!exp_err) begin
            check("rnd_x",      r.x, model_x(m, f));
            check("rnd_beats",  r.nbeats, BEATS);
            check("rnd_stable", r.unstable, 0);
            check("rnd_last",   r.bad_last, 0);
            check("rnd_first",  r.first_valid, LOGN + 2);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
